// File: rtl/read_stage_pkg.sv
// read_stage_pkg
// Shared types and widths for the read-stage response path.
// The request tag is recorded when the arbiter grants a read. It travels back
// alongside the returned VRF data so the requester can match the response.
package read_stage_pkg;

  localparam int READ_SOURCE_W = 4;
  localparam int INSTR_INDEX_W = 3;

  typedef struct packed {
    logic                     source;
    logic [READ_SOURCE_W-1:0] readSource;
    logic [INSTR_INDEX_W-1:0] instructionIndex;
  } read_resp_tag_t;

endpackage

// File: rtl/read_resp_slot_ring.sv
// read_resp_slot_ring
// Purpose: in-order slot storage for outstanding VRF reads. Each slot holds
//   the request tag, the returned data and a filled flag. Three wrapping
//   pointers track the slots:
//     alloc - next slot to allocate
//     fill  - oldest allocated slot that is still unfilled
//     head  - oldest allocated slot
// Ports:
//   clock, reset (async, active-low)
//   alloc_en/alloc_tag       - claim slot[alloc] for a newly granted read
//   fill_en/fill_store/data  - consume the oldest unfilled slot; fill_store=0
//                              advances past it without writing (bypass)
//   pop_en                   - retire the head slot
//   full, pending_any        - occupancy flags for grant and response gating
//   head_waiting             - head allocated and unfilled (READ_RESP_BYPASS_EN only)
//   head_filled/tag/data     - current head slot contents
// Configuration: READ_RESP_BYPASS_EN adds the head_waiting output.
module read_resp_slot_ring
  import read_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_en,
  input  read_resp_tag_t        alloc_tag,
  input  logic                  fill_en,
  input  logic                  fill_store,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  pop_en,
  output logic                  full,
  output logic                  pending_any,
`ifdef READ_RESP_BYPASS_EN
  output logic                  head_waiting,
`endif
  output logic                  head_filled,
  output read_resp_tag_t        head_tag,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      alloc_ptr;
  logic [PTR_W-1:0]      fill_ptr;
  logic [PTR_W-1:0]      head_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      pending;
  logic [DEPTH-1:0]      filled;
  read_resp_tag_t        tag_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two. The counters
  // move by the net of alloc/pop and alloc/fill, so all three events may
  // coincide in a single cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      count     <= '0;
      pending   <= '0;
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + PTR_W'(1);
      if (fill_en)  fill_ptr  <= fill_ptr + PTR_W'(1);
      if (pop_en)   head_ptr  <= head_ptr + PTR_W'(1);
      count   <= count + CNT_W'(alloc_en) - CNT_W'(pop_en);
      pending <= pending + CNT_W'(alloc_en) - CNT_W'(fill_en);
    end
  end

  // Slot contents. Allocation, fill and pop never target the same slot in
  // one cycle. The only exception is a bypassed response: fill and pop then
  // both hit the head, fill_store is low, and the slot simply retires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (alloc_en) begin
        tag_mem[alloc_ptr] <= alloc_tag;
        filled[alloc_ptr]  <= 1'b0;
      end
      if (fill_en && fill_store) begin
        data_mem[fill_ptr] <= fill_data;
        filled[fill_ptr]   <= 1'b1;
      end
      if (pop_en) filled[head_ptr] <= 1'b0;
    end
  end

  assign full        = (count == CNT_W'(DEPTH));
  assign pending_any = (pending != '0);
`ifdef READ_RESP_BYPASS_EN
  // Every allocated slot is still unfilled, so the head is the next to fill.
  assign head_waiting = pending_any && (pending == count);
`endif
  assign head_filled = filled[head_ptr];
  assign head_tag    = tag_mem[head_ptr];
  assign head_data   = data_mem[head_ptr];

endmodule

// File: rtl/read_stage_response_router.sv
// read_stage_response_router
// Purpose: routes in-order VRF read data back to the read-stage requester
//   (port 0 or 1) that won arbitration. The winner's tag is recorded on each
//   grant. The VRF cannot stall, so grants are throttled by slot credits.
// Ports:
//   clock, reset (async, active-low)
//   io_grant_*  - accepted arbiter grant carrying source and tag; io_grant_ready
//                 reports that a slot is free
//   io_resp_*   - VRF read data, returned in request order, never stalled
//   io_out_0_*, io_out_1_* - per-requester valid/ready delivery with echoed tags
//   io_error    - sticky flag: a response arrived with no slot waiting for it
// Configuration: define READ_RESP_BYPASS_EN to add a same-cycle path. A
//   response that lands on an empty head goes straight to its port. Without
//   the macro, delivery always comes from the registered slot.
module read_stage_response_router
  import read_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_grant_valid,
  output logic                     io_grant_ready,
  input  logic                     io_grant_bits_source,
  input  logic [READ_SOURCE_W-1:0] io_grant_bits_readSource,
  input  logic [INSTR_INDEX_W-1:0] io_grant_bits_instructionIndex,
  input  logic                     io_resp_valid,
  input  logic [DATA_WIDTH-1:0]    io_resp_bits_data,
  output logic                     io_out_0_valid,
  input  logic                     io_out_0_ready,
  output logic [DATA_WIDTH-1:0]    io_out_0_bits_data,
  output logic [READ_SOURCE_W-1:0] io_out_0_bits_readSource,
  output logic [INSTR_INDEX_W-1:0] io_out_0_bits_instructionIndex,
  output logic                     io_out_1_valid,
  input  logic                     io_out_1_ready,
  output logic [DATA_WIDTH-1:0]    io_out_1_bits_data,
  output logic [READ_SOURCE_W-1:0] io_out_1_bits_readSource,
  output logic [INSTR_INDEX_W-1:0] io_out_1_bits_instructionIndex,
  output logic                     io_error
);

  read_resp_tag_t        grant_tag;
  read_resp_tag_t        head_tag;
  logic                  full;
  logic                  pending_any;
  logic                  head_filled;
  logic                  alloc_en;
  logic                  fill_en;
  logic                  fill_store;
  logic                  pop_en;
  logic                  deliver_valid;
  logic                  target_ready;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] deliver_data;

  // A grant seen while no slot is free is ignored. io_grant_ready comes from
  // the registered count, so a pop from a full ring frees its credit a cycle later.
  assign io_grant_ready = ~full;
  assign alloc_en       = io_grant_valid & io_grant_ready;
  assign grant_tag      = {io_grant_bits_source, io_grant_bits_readSource,
                           io_grant_bits_instructionIndex};

  // A slot becomes fillable the cycle after its grant. A response with
  // nothing pending is dropped.
  assign fill_en      = io_resp_valid & pending_any;
  assign target_ready = head_tag.source ? io_out_1_ready : io_out_0_ready;

`ifdef READ_RESP_BYPASS_EN
  logic head_waiting;
  logic bypass_valid;

  // Offer the response straight to the head's port. If that port accepts it
  // the slot retires unwritten. Otherwise the data is stored as usual, and
  // the same bits are presented from the slot on the next cycle.
  assign bypass_valid  = io_resp_valid & head_waiting;
  assign deliver_valid = head_filled | bypass_valid;
  assign deliver_data  = head_filled ? head_data : io_resp_bits_data;
  assign fill_store    = ~(bypass_valid & target_ready);
`else
  assign deliver_valid = head_filled;
  assign deliver_data  = head_data;
  assign fill_store    = 1'b1;
`endif

  // Strict in-order delivery: a stalled head also blocks the other port.
  assign pop_en = deliver_valid & target_ready;

  read_resp_slot_ring #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ring (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_tag  (grant_tag),
    .fill_en    (fill_en),
    .fill_store (fill_store),
    .fill_data  (io_resp_bits_data),
    .pop_en     (pop_en),
    .full       (full),
    .pending_any(pending_any),
`ifdef READ_RESP_BYPASS_EN
    .head_waiting(head_waiting),
`endif
    .head_filled(head_filled),
    .head_tag   (head_tag),
    .head_data  (head_data)
  );

  // Only the port named by the head's source sees valid. The idle port's
  // bits are forced to zero.
  assign io_out_0_valid                 = deliver_valid & ~head_tag.source;
  assign io_out_0_bits_data             = io_out_0_valid ? deliver_data : '0;
  assign io_out_0_bits_readSource       = io_out_0_valid ? head_tag.readSource : '0;
  assign io_out_0_bits_instructionIndex = io_out_0_valid ? head_tag.instructionIndex : '0;
  assign io_out_1_valid                 = deliver_valid & head_tag.source;
  assign io_out_1_bits_data             = io_out_1_valid ? deliver_data : '0;
  assign io_out_1_bits_readSource       = io_out_1_valid ? head_tag.readSource : '0;
  assign io_out_1_bits_instructionIndex = io_out_1_valid ? head_tag.instructionIndex : '0;

  // Sticky error: a response that had no unfilled slot to land in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (io_resp_valid && !pending_any) begin
      error_q <= 1'b1;
    end
  end

  assign io_error = error_q;

endmodule

// File: tb/tb_read_stage_response_router.sv
// tb_read_stage_response_router
// Directed scenarios followed by a randomized run. The reference model is a
// queue of outstanding reads in grant order. Responses fill the oldest
// unanswered read, and only the oldest read may be delivered, to its source port.
module tb_read_stage_response_router;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 4;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  io_grant_valid = 1'b0;
  logic                  io_grant_ready;
  logic                  io_grant_bits_source = 1'b0;
  logic [3:0]            io_grant_bits_readSource = '0;
  logic [2:0]            io_grant_bits_instructionIndex = '0;
  logic                  io_resp_valid = 1'b0;
  logic [DATA_WIDTH-1:0] io_resp_bits_data = '0;
  logic                  io_out_0_valid;
  logic                  io_out_0_ready = 1'b0;
  logic [DATA_WIDTH-1:0] io_out_0_bits_data;
  logic [3:0]            io_out_0_bits_readSource;
  logic [2:0]            io_out_0_bits_instructionIndex;
  logic                  io_out_1_valid;
  logic                  io_out_1_ready = 1'b0;
  logic [DATA_WIDTH-1:0] io_out_1_bits_data;
  logic [3:0]            io_out_1_bits_readSource;
  logic [2:0]            io_out_1_bits_instructionIndex;
  logic                  io_error;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        src;
    logic [3:0]  rs;
    logic [2:0]  ii;
    logic [31:0] data;
    bit          filled;
  } read_t;

  read_t       mq[$];
  bit          merr;
  logic        exp_ready, exp_err, exp_v0, exp_v1;
  logic [38:0] exp_b0, exp_b1;
  bit          exp_bypass;

  always #5 clock = ~clock;

  read_stage_response_router #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_grant_valid                (io_grant_valid),
    .io_grant_ready                (io_grant_ready),
    .io_grant_bits_source          (io_grant_bits_source),
    .io_grant_bits_readSource      (io_grant_bits_readSource),
    .io_grant_bits_instructionIndex(io_grant_bits_instructionIndex),
    .io_resp_valid                 (io_resp_valid),
    .io_resp_bits_data             (io_resp_bits_data),
    .io_out_0_valid                (io_out_0_valid),
    .io_out_0_ready                (io_out_0_ready),
    .io_out_0_bits_data            (io_out_0_bits_data),
    .io_out_0_bits_readSource      (io_out_0_bits_readSource),
    .io_out_0_bits_instructionIndex(io_out_0_bits_instructionIndex),
    .io_out_1_valid                (io_out_1_valid),
    .io_out_1_ready                (io_out_1_ready),
    .io_out_1_bits_data            (io_out_1_bits_data),
    .io_out_1_bits_readSource      (io_out_1_bits_readSource),
    .io_out_1_bits_instructionIndex(io_out_1_bits_instructionIndex),
    .io_error                      (io_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pendingCount();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  task automatic applyStimulus(input logic gv, input logic gsrc, input logic [3:0] grs,
                               input logic [2:0] gii, input logic rv, input logic [31:0] rd,
                               input logic r0, input logic r1);
    io_grant_valid                 = gv;
    io_grant_bits_source           = gsrc;
    io_grant_bits_readSource       = grs;
    io_grant_bits_instructionIndex = gii;
    io_resp_valid                  = rv;
    io_resp_bits_data              = rd;
    io_out_0_ready                 = r0;
    io_out_1_ready                 = r1;
  endtask

  // Expected outputs for the current cycle from the outstanding-read queue.
  task automatic computeExpect();
    exp_ready  = (mq.size() < DEPTH);
    exp_err    = merr;
    exp_v0     = 1'b0;
    exp_v1     = 1'b0;
    exp_b0     = '0;
    exp_b1     = '0;
    exp_bypass = 1'b0;
    if (mq.size() > 0 && mq[0].filled) begin
      if (mq[0].src) begin exp_v1 = 1'b1; exp_b1 = {mq[0].data, mq[0].rs, mq[0].ii}; end
      else           begin exp_v0 = 1'b1; exp_b0 = {mq[0].data, mq[0].rs, mq[0].ii}; end
    end
`ifdef READ_RESP_BYPASS_EN
    else if (mq.size() > 0 && pendingCount() == mq.size() && io_resp_valid) begin
      exp_bypass = 1'b1;
      if (mq[0].src) begin exp_v1 = 1'b1; exp_b1 = {io_resp_bits_data, mq[0].rs, mq[0].ii}; end
      else           begin exp_v0 = 1'b1; exp_b0 = {io_resp_bits_data, mq[0].rs, mq[0].ii}; end
    end
`endif
  endtask

  task automatic checkOutput();
    check("grant_ready", 64'(io_grant_ready), 64'(exp_ready));
    check("error", 64'(io_error), 64'(exp_err));
    check("out0_valid", 64'(io_out_0_valid), 64'(exp_v0));
    check("out1_valid", 64'(io_out_1_valid), 64'(exp_v1));
    check("out0_bits", 64'({io_out_0_bits_data, io_out_0_bits_readSource,
                            io_out_0_bits_instructionIndex}), 64'(exp_b0));
    check("out1_bits", 64'({io_out_1_bits_data, io_out_1_bits_readSource,
                            io_out_1_bits_instructionIndex}), 64'(exp_b1));
  endtask

  task automatic evalCycle();
    @(negedge clock);
    computeExpect();
    checkOutput();
  endtask

  // Apply this cycle's events to the model at the rising edge.
  task automatic advanceCycle();
    bit pop;
    int pend;
    read_t r;
    pop  = (exp_v0 && io_out_0_ready) || (exp_v1 && io_out_1_ready);
    pend = pendingCount();
    @(posedge clock);
    if (io_resp_valid) begin
      if (pend == 0) merr = 1'b1;
      else if (!(exp_bypass && pop)) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].filled) begin
            mq[i].filled = 1'b1;
            mq[i].data   = io_resp_bits_data;
            break;
          end
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (io_grant_valid && exp_ready) begin
      r.src = io_grant_bits_source; r.rs = io_grant_bits_readSource;
      r.ii = io_grant_bits_instructionIndex; r.data = '0; r.filled = 1'b0;
      mq.push_back(r);
    end
    #1;
  endtask

  task automatic cycle();
    evalCycle();
    advanceCycle();
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 32'h0, r0, r1);
    repeat (n) cycle();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_grant_ready", 64'(io_grant_ready), 64'(1));
    check("rst_error", 64'(io_error), 64'(0));
    check("rst_out0_valid", 64'(io_out_0_valid), 64'(0));
    check("rst_out1_valid", 64'(io_out_1_valid), 64'(0));
    check("rst_out0_data", 64'(io_out_0_bits_data), 64'(0));
    check("rst_out1_data", 64'(io_out_1_bits_data), 64'(0));
    mq.delete();
    merr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    merr = 1'b0;
    #2;
    resetDut();

    // Single read to port 1.
    applyStimulus(1'b1, 1'b1, 4'h5, 3'd2, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    evalCycle();
`ifdef READ_RESP_BYPASS_EN
    check("t1_same_cycle_valid1", 64'(io_out_1_valid), 64'(1));
`else
    check("t1_no_early_valid1", 64'(io_out_1_valid), 64'(0));
`endif
    advanceCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    evalCycle();
`ifndef READ_RESP_BYPASS_EN
    check("t1_valid1", 64'(io_out_1_valid), 64'(1));
    check("t1_bits1", 64'({io_out_1_bits_data, io_out_1_bits_readSource,
                           io_out_1_bits_instructionIndex}), 64'({32'hDEADBEEF, 4'h5, 3'd2}));
`endif
    check("t1_valid0", 64'(io_out_0_valid), 64'(0));
    advanceCycle();
    idle(2, 1'b1, 1'b1);

    // Fill the ring, try an extra grant, then release one slot.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, i[0], 4'(i + 8), 3'(i), 1'b0, 32'h0, 1'b1, 1'b1);
      cycle();
    end
    applyStimulus(1'b1, 1'b0, 4'hF, 3'd7, 1'b0, 32'h0, 1'b1, 1'b1);
    evalCycle();
    check("t2_full_not_ready", 64'(io_grant_ready), 64'(0));
    advanceCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'hA0A0_0001, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    evalCycle();
    check("t2_pop_cycle_ready", 64'(io_grant_ready), 64'(0));
    advanceCycle();
    evalCycle();
    check("t2_after_pop_ready", 64'(io_grant_ready), 64'(1));
    advanceCycle();
    for (int i = 0; i < DEPTH - 1; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'hA0A0_0002 + 32'(i), 1'b1, 1'b1);
      cycle();
    end
    idle(4, 1'b1, 1'b1);

    // Stalled head on port 0 blocks a ready port 1.
    applyStimulus(1'b1, 1'b0, 4'h1, 3'd1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b1, 1'b1, 4'h2, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'h1111_0000, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'h2222_0001, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      evalCycle();
      check("t3_port1_blocked", 64'(io_out_1_valid), 64'(0));
      check("t3_port0_held", 64'(io_out_0_data_held()), 64'(32'h1111_0000));
      advanceCycle();
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    evalCycle();
    check("t3_port0_release", 64'(io_out_0_valid), 64'(1));
    advanceCycle();
    evalCycle();
    check("t3_port1_data", 64'(io_out_1_bits_data), 64'(32'h2222_0001));
    advanceCycle();
    idle(2, 1'b1, 1'b1);

    // Grant, fill and pop in one cycle.
    applyStimulus(1'b1, 1'b0, 4'h3, 3'd3, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 1'b1, 4'h4, 3'd4, 1'b1, 32'hAAAA_0000, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 1'b0, 4'h6, 3'd5, 1'b1, 32'hBBBB_0000, 1'b1, 1'b0);
    evalCycle();
    check("t4_head_a", 64'(io_out_0_bits_data), 64'(32'hAAAA_0000));
    advanceCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    evalCycle();
    check("t4_ready_count_kept", 64'(io_grant_ready), 64'(1));
    check("t4_head_b", 64'({io_out_1_valid, io_out_1_bits_data}), 64'({1'b1, 32'hBBBB_0000}));
    advanceCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'hCCCC_0000, 1'b1, 1'b1);
    cycle();
    idle(2, 1'b1, 1'b1);

    // Reset with reads in flight, then a stray response.
    applyStimulus(1'b1, 1'b1, 4'h7, 3'd6, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
    cycle();
    resetDut();
    applyStimulus(1'b0, 1'b0, 4'h0, 3'd0, 1'b1, 32'h7777_7777, 1'b1, 1'b1);
    cycle();
    idle(3, 1'b1, 1'b1);
    check("t5_error_sticky", 64'(io_error), 64'(1));
    check("t5_no_valid", 64'({io_out_0_valid, io_out_1_valid}), 64'(0));
    resetDut();

    // Randomized traffic; responses only while reads are pending.
    for (int n = 0; n < 400; n++) begin
      logic rv;
      rv = (pendingCount() > 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                    3'($urandom), rv, $urandom, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0));
      cycle();
    end
    idle(8, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Port 0 data gated by its valid, so a dropped valid shows as a wrong value.
  function automatic logic [31:0] io_out_0_data_held();
    return io_out_0_valid ? io_out_0_bits_data : 32'h0;
  endfunction

endmodule
